muladd: RTL
===========

# muladd

Iterative shift-and-add multiply-accumulate unit computing `res = a*b + c` over unsigned `WIDTH`-bit operands. It is the inverse of the divide/modulo unit: given a divisor, a quotient and a remainder, it reconstructs the dividend. It is used in the prime-generator datapath to check divider results and to compute candidate multiples. It uses the same edge-triggered `go` / `ready` / `error` handshake as the divider, so the sequencer drives both identically.

## Interface
- `WIDTH_LOG`, default 4: operand width is `WIDTH = 1 << WIDTH_LOG`.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `go`  in  1: start request; only a 0->1 transition, sampled at a clock edge, starts an operation.
- `a`  in  WIDTH: multiplicand; sampled only at the start edge.
- `b`  in  WIDTH: multiplier; sampled only at the start edge.
- `c`  in  WIDTH: addend; sampled only at the start edge.
- `ready`  out  1: unit idle; result or error is valid.
- `error`  out  1: the last operation overflowed `WIDTH` bits.
- `res`  out  WIDTH: result; valid only when `ready=1` and `error=0`.

## Operation
- States: `READY`, `MULTIPLY`, `ERROR`.
- Internal registers:
  - `acc`: `WIDTH+1` bits, the carry bit included.
  - `areg`: `WIDTH` bits.
  - `breg`: `WIDTH` bits.
  - `a_ovf`: 1 bit, sticky.
  - `go_prev`: 1 bit.
- Start condition: `go && !go_prev`. It has priority over the current state, in any state including `MULTIPLY`.
  - The in-flight operation is abandoned.
  - Load `acc=c`, `areg=a`, `breg=b`, `a_ovf=0`.
  - Next state is `MULTIPLY` if `b!=0`, else `READY`.
- `MULTIPLY` step, one per cycle:
  - If `breg[0]=1` and `a_ovf=1`: next state `ERROR`.
  - Else if `breg[0]=1`: `acc = acc + areg`. If the carry bit of the sum is set, next state `ERROR`.
  - Then `a_ovf |= areg[WIDTH-1]`, `areg <<= 1`, `breg >>= 1`.
  - If the new `breg==0` and no error occurred: next state `READY`.
- Overflow rule: `error=1` if and only if the exact value `a*b + c > 2^WIDTH - 1`. Detection aborts the operation immediately. No further iterations run.
- `READY` and `ERROR` hold until the next start condition. No start condition means no state change.
- `res = acc[WIDTH-1:0]`.
  - During `MULTIPLY` it shows partial sums and carries no meaning.
  - After `ERROR` its value is unspecified.
- `b==0`: result is `c` and can never overflow. `ready` stays 1 throughout.
- `a==0`, `b!=0`: iterates normally; result is `c`.
- Operands changing while busy have no effect. Only the start edge samples them.

## Timing
- Reset values:
  - `ready=1`, `error=0`, state `READY`, `go_prev=0`.
  - `res`, `acc`, `areg`, `breg` are X. `a_ovf=0`.
- `go` held high through reset deassertion counts as a rising edge at the first non-reset clock edge.
- `ready` and `error` are registered and computed from the next state at the same edge: `ready = (next==READY || next==ERROR)`, `error = (next==ERROR)`.
- Let E0 be the clock edge that samples the start condition, with `b!=0`:
  - `ready` goes 0 after E0.
  - Iterations happen at E1..En, where `n = msb_index(b) + 1`.
  - `ready` goes 1 at En with `res` valid.
  - Latency is therefore n cycles, worst case `WIDTH`.
- With `b==0`: `res=c` is valid after E0, and `ready` never drops.
- Overflow is flagged at edge Ek, where k is the iteration that detects it. k ≤ n. At that edge `ready` and `error` both become 1.
- `error` clears at the next start edge: it is 0 after E0 of the new operation.
- Back-to-back operations:
  - `go` must return to 0 for at least one sampled edge between starts.
  - The earliest restart is the edge after the `go` falling sample.
- `rst` asserted mid-operation wins over everything. After that edge all reset values apply, and no result is produced.

## Test plan
All cases use `WIDTH_LOG=4`.
- `a=3, b=5, c=7`, `go` pulse -> `ready` low for E1..E2, high at E3; `res=22`, `error=0`.
- `a=0x1234, b=0, c=0x55` -> `ready` stays 1; `res=0x55` after E0; `error=0`.
- `a=0x00FF, b=0x0101, c=0` -> `res=0xFFFF`, `error=0`, `ready` at E9.
- Overflow cases:
  - `a=0xFFFF, b=1, c=1` -> `error=1`, `ready=1` at E1.
  - `a=0x0100, b=0x0100, c=0` -> `error=1` at E9, through the `a_ovf` path.
  - A following `go` with `a=2, b=2, c=0` clears `error` and gives `res=4`.
- Restart and held `go`:
  - Start `a=0x7, b=0x8000, c=0`. At E3 drop `go`; at E4 raise it with `a=5, b=3, c=1`. Result: `res=16`, `ready` at E4+2.
  - Holding `go` high for 20 cycles gives exactly one operation.
- `rst` at E2 of `a=9, b=9, c=0` -> `ready=1`, `error=0` next cycle. No completion pulse follows. A subsequent start computes correctly.

Source files
------------

// File: rtl/muladd.sv
// muladd: iterative shift-and-add multiply-accumulate, res = a*b + c.
// Unsigned WIDTH-bit operands; any result that does not fit in WIDTH bits
// is reported through error instead of res. Handshake matches the divider:
// a rising edge on go starts an operation, ready/error report its outcome.
module muladd #(
    parameter int WIDTH_LOG = 4,
    localparam int WIDTH = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);

    localparam logic [1:0] ST_READY    = 2'd0;
    localparam logic [1:0] ST_MULTIPLY = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             go_prev;
    logic             start;

    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] areg_n;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] breg_n;
    logic             a_ovf;
    logic             a_ovf_n;

    assign start = go && !go_prev;
    assign sum   = acc + {1'b0, areg};
    assign res   = acc[WIDTH-1:0];

    // Next-state and datapath update: a start edge always wins, otherwise
    // one multiplier bit is consumed per cycle while multiplying. a_ovf
    // remembers that a set bit has been shifted out of areg, so any later
    // set multiplier bit means the product no longer fits.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        areg_n  = areg;
        breg_n  = breg;
        a_ovf_n = a_ovf;
        if (start) begin
            acc_n   = {1'b0, c};
            areg_n  = a;
            breg_n  = b;
            a_ovf_n = 1'b0;
            state_n = (b != '0) ? ST_MULTIPLY : ST_READY;
        end else if (state == ST_MULTIPLY) begin
            if (breg[0] && a_ovf) begin
                state_n = ST_ERROR;
            end else begin
                if (breg[0]) begin
                    acc_n = sum;
                    if (sum[WIDTH]) begin
                        state_n = ST_ERROR;
                    end
                end
                a_ovf_n = a_ovf | areg[WIDTH-1];
                areg_n  = areg << 1;
                breg_n  = breg >> 1;
                if (breg_n == '0 && state_n != ST_ERROR) begin
                    state_n = ST_READY;
                end
            end
        end
    end

    // Control state and registered status flags, derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_READY;
            go_prev <= 1'b0;
            a_ovf   <= 1'b0;
            ready   <= 1'b1;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            go_prev <= go;
            a_ovf   <= a_ovf_n;
            ready   <= (state_n == ST_READY) || (state_n == ST_ERROR);
            error   <= (state_n == ST_ERROR);
        end
    end

    // Operand and accumulator registers carry no reset; their contents only
    // matter after a start edge has loaded them.
    always_ff @(posedge clk) begin
        acc  <= acc_n;
        areg <= areg_n;
        breg <= breg_n;
    end

endmodule
